gshare_update_scheduler: RTL and testbench

Buffers resolved-branch predictor updates from two resolution slots and issues them, one per cycle, to the GShare single update interface (write enable, original PC, taken). It sits between the branch-resolution stage and the direction predictor. It preserves program order between slots, applies back-pressure when full, honours a predictor hold, and discards pending updates on pipeline flush.

---
 rtl/gshare_ctrl_pkg.sv | 18 +
 rtl/gshare_update_scheduler_upd_fifo.sv | 67 ++++++
 rtl/gshare_update_scheduler.sv | 105 ++++++++++
 tb/tb_gshare_update_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// gshare_ctrl_pkg
// Shared definitions for the GShare predictor update path.
//   PC_BITS_DEFAULT : default branch PC width of a queued update
//   DEPTH_DEFAULT   : default number of update queue entries
//   upd_entry_t     : one queued update {pc, taken} at the default PC width
// ----------------------------------------------------------------------------
package gshare_ctrl_pkg;

  localparam int PC_BITS_DEFAULT = 32;
  localparam int DEPTH_DEFAULT   = 4;

  typedef struct packed {
    logic [PC_BITS_DEFAULT-1:0] pc;
    logic                       taken;
  } upd_entry_t;

endpackage : gshare_ctrl_pkg

// File: rtl/gshare_update_scheduler_upd_fifo.sv
// ----------------------------------------------------------------------------
// upd_fifo
// Two-write / one-read circular buffer for resolved-branch updates.
// Owns the head/tail pointers, the entry count and the storage.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous clear of pointers and count (pipeline flush)
//   wr_a, data_a  : write the older entry at tail
//   wr_b, data_b  : write the younger entry after A (or at tail if A idle)
//   rd            : pop the head entry
//   rd_data       : current head entry
//   count         : registered number of valid entries, 0..DEPTH
// The caller guarantees there is room for every write issued.
// ----------------------------------------------------------------------------
module upd_fifo
  import gshare_ctrl_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEFAULT,
  parameter type entry_t = upd_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_a,
  input  entry_t           data_a,
  input  logic             wr_b,
  input  entry_t           data_b,
  input  logic             rd,
  output entry_t           rd_data,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_b;
  entry_t           mem [DEPTH];

  // B lands one slot past A when both are written, otherwise at tail.
  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign tail_b  = wr_a ? tail + PTR_W'(1) : tail;
  assign rd_data = mem[head];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: storage is reset (not just the pointers) because the head
      // entry drives the predictor PC/taken and must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_a) mem[tail]   <= data_a;
      if (wr_b) mem[tail_b] <= data_b;
      tail  <= tail + PTR_W'(wr_a) + PTR_W'(wr_b);
      if (rd) head <= head + PTR_W'(1);
      count <= count + CNT_W'(wr_a) + CNT_W'(wr_b) - CNT_W'(rd);
    end
  end

endmodule : upd_fifo

// File: rtl/gshare_update_scheduler.sv
// ----------------------------------------------------------------------------
// gshare_update_scheduler
// Buffers resolved-branch predictor updates from two resolution slots and
// issues them one per cycle to the GShare single update port, preserving
// program order (slot A older than slot B).
//   clk, rst                    : clock, asynchronous active-high reset
//   valid_a/pc_a/taken_a/ready_a: older resolution slot, valid/ready handshake
//   valid_b/pc_b/taken_b/ready_b: younger resolution slot, valid/ready handshake
//   flush                       : drop queued and same-cycle updates
//   hold                        : predictor cannot take an update this cycle
//   upd_en/upd_pc/upd_taken     : predictor write enable, PC and direction
//   occupancy                   : registered queue entry count
// Optional build macro GSHARE_UPD_STATS_EN adds:
//   issued_cnt                  : number of upd_en cycles (wraps, not flushed)
//   stall_cnt                   : cycles with a valid slot refused (no flush)
// ----------------------------------------------------------------------------
module gshare_update_scheduler
  import gshare_ctrl_pkg::*;
#(
  parameter int  PC_BITS = PC_BITS_DEFAULT,
  parameter int  DEPTH   = DEPTH_DEFAULT,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_a,
  input  logic [PC_BITS-1:0] pc_a,
  input  logic               taken_a,
  output logic               ready_a,
  input  logic               valid_b,
  input  logic [PC_BITS-1:0] pc_b,
  input  logic               taken_b,
  output logic               ready_b,
  input  logic               flush,
  input  logic               hold,
  output logic               upd_en,
  output logic [PC_BITS-1:0] upd_pc,
  output logic               upd_taken,
`ifdef GSHARE_UPD_STATS_EN
  output logic [31:0]        issued_cnt,
  output logic [31:0]        stall_cnt,
`endif
  output logic [CNT_W-1:0]   occupancy
);

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic               taken;
  } entry_t;

  entry_t entry_a;
  entry_t entry_b;
  entry_t head_entry;
  logic   acc_a;
  logic   acc_b;

  // Readiness looks only at registered occupancy: a same-cycle dequeue
  // frees no room, which keeps ready off the predictor-hold timing path.
  assign ready_a = !flush && (occupancy <  CNT_W'(DEPTH));
  assign ready_b = !flush && (occupancy <= CNT_W'(DEPTH - 2));

  assign acc_a = valid_a && ready_a;
  assign acc_b = valid_b && ready_b;

  assign entry_a = '{pc: pc_a, taken: taken_a};
  assign entry_b = '{pc: pc_b, taken: taken_b};

  assign upd_en    = !flush && !hold && (occupancy != '0);
  assign upd_pc    = head_entry.pc;
  assign upd_taken = head_entry.taken;

  upd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_a    (acc_a),
    .data_a  (entry_a),
    .wr_b    (acc_b),
    .data_b  (entry_b),
    .rd      (upd_en),
    .rd_data (head_entry),
    .count   (occupancy)
  );

`ifdef GSHARE_UPD_STATS_EN
  logic stalled;

  // ready is already low during flush, so flush must be masked explicitly.
  assign stalled = !flush && ((valid_a && !ready_a) || (valid_b && !ready_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (upd_en)  issued_cnt <= issued_cnt + 32'd1;
      if (stalled) stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule : gshare_update_scheduler

// File: tb/tb_gshare_update_scheduler.sv
// ----------------------------------------------------------------------------
// tb_gshare_update_scheduler
// Directed bench: a table of per-cycle vectors (inputs plus expected outputs
// in that cycle) followed by hand-written asynchronous-reset and optional
// statistics sequences. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gshare_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, taken_a, valid_b, taken_b, flush, hold;
  logic [31:0] pc_a, pc_b;
  logic        ready_a, ready_b, upd_en, upd_taken;
  logic [31:0] upd_pc;
  logic [2:0]  occupancy;
`ifdef GSHARE_UPD_STATS_EN
  logic [31:0] issued_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gshare_update_scheduler #(.PC_BITS(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_a    (valid_a),
    .pc_a       (pc_a),
    .taken_a    (taken_a),
    .ready_a    (ready_a),
    .valid_b    (valid_b),
    .pc_b       (pc_b),
    .taken_b    (taken_b),
    .ready_b    (ready_b),
    .flush      (flush),
    .hold       (hold),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
`ifdef GSHARE_UPD_STATS_EN
    .issued_cnt (issued_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .occupancy  (occupancy)
  );

  typedef struct {
    logic        va;
    logic [31:0] pa;
    logic        ta;
    logic        vb;
    logic [31:0] pb;
    logic        tb;
    logic        fl;
    logic        hd;
    logic        e_ra;
    logic        e_rb;
    logic        e_en;
    logic [31:0] e_pc;
    logic        e_tk;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic va, input logic [31:0] pa, input logic ta,
    input logic vb, input logic [31:0] pb, input logic tb,
    input logic fl, input logic hd,
    input logic e_ra, input logic e_rb, input logic e_en,
    input logic [31:0] e_pc, input logic e_tk, input logic [2:0] e_occ);
    vec_t v;
    v.va = va; v.pa = pa; v.ta = ta; v.vb = vb; v.pb = pb; v.tb = tb;
    v.fl = fl; v.hd = hd; v.e_ra = e_ra; v.e_rb = e_rb; v.e_en = e_en;
    v.e_pc = e_pc; v.e_tk = e_tk; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic drive(input logic va, input logic [31:0] pa, input logic ta,
                       input logic vb, input logic [31:0] pb, input logic tb,
                       input logic fl, input logic hd);
    valid_a = va; pc_a = pa; taken_a = ta;
    valid_b = vb; pc_b = pb; taken_b = tb;
    flush = fl; hold = hd;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Each row: inputs of one cycle, then expected ready_a, ready_b, upd_en,
    // head pc/taken (checked only when occupancy != 0) and occupancy.
    //          va pa            ta vb pb            tb fl hd  ra rb en pc            tk occ
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 0, 32'h0,   0, 0)); // idle after reset
    vecs.push_back(mk(1, 32'h100, 1, 0, 32'h0,   0, 0, 0,  1, 1, 0, 32'h0,   0, 0)); // A alone
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 1, 32'h100, 1, 1)); // issue one cycle later
    vecs.push_back(mk(1, 32'h200, 0, 1, 32'h204, 1, 0, 0,  1, 1, 0, 32'h0,   0, 0)); // A+B together
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 1, 32'h200, 0, 2)); // A first
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 1, 32'h204, 1, 1)); // then B
    vecs.push_back(mk(1, 32'h300, 1, 1, 32'h304, 0, 0, 1,  1, 1, 0, 32'h0,   0, 0)); // hold, fill
    vecs.push_back(mk(1, 32'h308, 1, 0, 32'h0,   0, 0, 1,  1, 1, 0, 32'h300, 1, 2)); // hold, A only
    vecs.push_back(mk(1, 32'h30c, 0, 1, 32'h310, 1, 0, 1,  1, 0, 0, 32'h300, 1, 3)); // occ3: B refused
    vecs.push_back(mk(1, 32'h314, 1, 1, 32'h318, 1, 0, 1,  0, 0, 0, 32'h300, 1, 4)); // full: both refused
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  0, 0, 1, 32'h300, 1, 4)); // release hold
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 0, 1, 32'h304, 0, 3)); // wrapped entry 0
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 1, 32'h308, 1, 2));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 1, 32'h30c, 0, 1));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 0, 32'h0,   0, 0)); // drained
    vecs.push_back(mk(1, 32'h400, 1, 1, 32'h404, 0, 0, 1,  1, 1, 0, 32'h0,   0, 0)); // build occ3
    vecs.push_back(mk(1, 32'h408, 1, 0, 32'h0,   0, 0, 1,  1, 1, 0, 32'h400, 1, 2));
    vecs.push_back(mk(1, 32'h500, 1, 0, 32'h0,   0, 1, 0,  0, 0, 0, 32'h400, 1, 3)); // flush
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 0, 32'h0,   0, 0)); // emptied
    vecs.push_back(mk(1, 32'h600, 0, 0, 32'h0,   0, 0, 0,  1, 1, 0, 32'h0,   0, 0)); // fresh entry
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 1, 32'h600, 0, 1));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 0,  1, 1, 0, 32'h0,   0, 0));

    // Reset state, sampled while reset is still asserted and after release.
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_upd_en",    32'(upd_en),    32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_upd_pc",    upd_pc,         32'h0);
    check("rst_upd_taken", 32'(upd_taken), 32'd0);
    check("rst_ready_a",   32'(ready_a),   32'd1);
    check("rst_ready_b",   32'(ready_b),   32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].va, vecs[i].pa, vecs[i].ta, vecs[i].vb, vecs[i].pb, vecs[i].tb,
            vecs[i].fl, vecs[i].hd);
      #1;
      check($sformatf("v%0d_ready_a", i),   32'(ready_a),   32'(vecs[i].e_ra));
      check($sformatf("v%0d_ready_b", i),   32'(ready_b),   32'(vecs[i].e_rb));
      check($sformatf("v%0d_upd_en", i),    32'(upd_en),    32'(vecs[i].e_en));
      check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      if (vecs[i].e_occ != 3'd0) begin
        check($sformatf("v%0d_upd_pc", i),    upd_pc,         vecs[i].e_pc);
        check($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_tk));
      end
    end

    // Asynchronous reset in the middle of a cycle with two entries queued.
    @(negedge clk);
    drive(1, 32'h700, 0, 1, 32'h704, 1, 0, 0);
    @(negedge clk);
    idle();
    #1;
    check("pre_arst_upd_en",    32'(upd_en),    32'd1);
    check("pre_arst_occupancy", 32'(occupancy), 32'd2);
    check("pre_arst_upd_pc",    upd_pc,         32'h700);
    #1;
    rst = 1'b1;
    #1;
    check("arst_upd_en",    32'(upd_en),    32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    check("arst_upd_pc",    upd_pc,         32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_arst_occupancy", 32'(occupancy), 32'd0);
    check("post_arst_upd_en",    32'(upd_en),    32'd0);
    @(negedge clk);
    drive(1, 32'h800, 1, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    idle();
    #1;
    check("post_arst_first_en", 32'(upd_en),    32'd1);
    check("post_arst_first_pc", upd_pc,         32'h800);
    check("post_arst_first_occ", 32'(occupancy), 32'd1);

`ifdef GSHARE_UPD_STATS_EN
    do_reset();
    #1;
    check("stats_rst_issued", issued_cnt, 32'd0);
    check("stats_rst_stall",  stall_cnt,  32'd0);
    @(negedge clk); drive(1, 32'h900, 1, 1, 32'h904, 1, 0, 1); // occ 0 -> 2
    @(negedge clk); drive(1, 32'h908, 1, 1, 32'h90c, 1, 0, 1); // occ 2 -> 4
    @(negedge clk); drive(1, 32'h910, 1, 0, 32'h0,   0, 0, 1); // stall 1
    @(negedge clk); drive(1, 32'h914, 1, 1, 32'h918, 1, 0, 1); // stall 2
    @(negedge clk); drive(0, 32'h0,   0, 1, 32'h91c, 1, 0, 1); // stall 3
    @(negedge clk); drive(1, 32'h920, 1, 0, 32'h0,   0, 1, 0); // flush: not a stall
    @(negedge clk); drive(1, 32'h924, 1, 1, 32'h928, 0, 0, 1); // occ 0 -> 2
    @(negedge clk); drive(1, 32'h92c, 1, 1, 32'h930, 0, 0, 1); // occ 2 -> 4
    @(negedge clk); idle();                                    // issue 1
    @(negedge clk);                                            // issue 2
    @(negedge clk);                                            // issue 3
    @(negedge clk);                                            // issue 4
    @(negedge clk); drive(1, 32'h934, 0, 0, 32'h0, 0, 0, 0);
    @(negedge clk); idle();                                    // issue 5
    @(negedge clk);
    #1;
    check("stats_issued", issued_cnt, 32'd5);
    check("stats_stall",  stall_cnt,  32'd3);
    force dut.issued_cnt = 32'hFFFF_FFFF;
    drive(1, 32'h940, 1, 0, 32'h0, 0, 0, 0);
    #1;
    release dut.issued_cnt;
    @(negedge clk);
    idle();
    #1;
    check("stats_preload", issued_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    check("stats_wrap", issued_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gshare_update_scheduler
